// File: rtl/bp_be_pkg.sv
// bp_be_pkg
// Shared types for the BE accelerator writeback engine.
//   bp_be_accel_wb_state_e : engine flush state (run / drain / done)
//   bp_be_accel_wb_field_e : CSR field selector, the low two bits of csr_addr_i
//   safe_clog2             : index width that never collapses to zero bits
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_drain = 2'd1,
        e_done  = 2'd2
    } bp_be_accel_wb_state_e;

    typedef enum logic [1:0] {
        e_wb_ptr    = 2'd0,
        e_wb_stride = 2'd1,
        e_wb_count  = 2'd2,
        e_wb_status = 2'd3
    } bp_be_accel_wb_field_e;

    localparam int wb_csr_width_lp    = 64;
    localparam int wb_stride_width_lp = 16;
    localparam int wb_count_width_lp  = 32;

    // A single destination still needs a one-bit index field.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small
// Small registered FIFO, one write port and one read port, no bypass.
// Output data is only visible the cycle after it was written.
//   clk_i, reset_n_i  : clock, synchronous active-low reset
//   v_i, ready_o      : write valid, space available (ready/valid)
//   data_i            : write data
//   v_o, data_o       : head valid and head data
//   yumi_i            : consume the head this cycle (only when v_o)
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt_r != cnt_w_lp'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push) wptr_r <= ptr_inc(wptr_r);
            if (pop)  rptr_r <= ptr_inc(rptr_r);
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; cnt_r alone decides what is valid,
    // and leaving the array reset-free keeps it mappable to plain flops or RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_be_accel_wb_engine.sv
// bp_be_accel_wb_engine
// Multi-destination writeback engine. Result beats tagged with a destination
// are buffered, then issued as one uncached write each at that destination's
// pointer, which advances by a signed per-destination stride. Outstanding
// write acks are tracked and a flush handshake drains everything for fences.
// Optional: BP_BE_ACCEL_WB_ALIGN_CHECK_EN drops head beats whose pointer is not
// aligned to the beat size (flags err); undefined, unaligned writes issue as-is.
// Ports:
//   clk_i, reset_n_i               : clock, synchronous active-low reset
//   csr_w_v_i/csr_addr_i/csr_data_i: CSR write, addr = {dest, field}
//   csr_data_o                     : combinational read of csr_addr_i
//   in_v_i/in_ready_and_o/in_data_i/in_dest_i : result beat input
//   wr_v_o/wr_ready_and_i/wr_addr_o/wr_data_o : write request output
//   ack_v_i                        : one write acknowledged
//   flush_i / flush_done_o         : drain request / one-cycle done pulse
//   idle_o, err_o                  : nothing buffered or outstanding / sticky error
module bp_be_accel_wb_engine
    import bp_be_pkg::*;
#(
    parameter int num_dest_p        = 4,
    parameter int data_width_p      = 128,
    parameter int addr_width_p      = 40,
    parameter int max_outstanding_p = 8,
    parameter int fifo_els_p        = 2,
    localparam int dest_w_lp        = safe_clog2(num_dest_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       csr_w_v_i,
    input  logic [dest_w_lp+1:0]       csr_addr_i,
    input  logic [wb_csr_width_lp-1:0] csr_data_i,
    output logic [wb_csr_width_lp-1:0] csr_data_o,
    input  logic [data_width_p-1:0]    in_data_i,
    input  logic [dest_w_lp-1:0]       in_dest_i,
    input  logic                       in_v_i,
    output logic                       in_ready_and_o,
    output logic [addr_width_p-1:0]    wr_addr_o,
    output logic [data_width_p-1:0]    wr_data_o,
    output logic                       wr_v_o,
    input  logic                       wr_ready_and_i,
    input  logic                       ack_v_i,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic                       idle_o,
    output logic                       err_o
);

    localparam int outst_w_lp = $clog2(max_outstanding_p + 1);
    localparam int bytes_lp   = data_width_p / 8;

    logic [addr_width_p-1:0]       ptr_r    [num_dest_p];
    logic [wb_stride_width_lp-1:0] stride_r [num_dest_p];
    logic [wb_count_width_lp-1:0]  count_r  [num_dest_p];
    logic [num_dest_p-1:0]         done_r;
    logic                          err_r;
    logic [outst_w_lp-1:0]         outst_r;
    bp_be_accel_wb_state_e         state_r;
    logic                          flush_done_r;

    // Input buffer
    logic                              fifo_ready, fifo_v, fifo_push, fifo_yumi;
    logic [data_width_p+dest_w_lp-1:0] fifo_data;

    assign in_ready_and_o = reset_n_i & (state_r == e_run) & fifo_ready;
    assign fifo_push      = in_v_i & in_ready_and_o;

    bsg_fifo_1r1w_small #(
        .width_p(data_width_p + dest_w_lp),
        .els_p  (fifo_els_p)
    ) in_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (fifo_push),
        .ready_o  (fifo_ready),
        .data_i   ({in_dest_i, in_data_i}),
        .v_o      (fifo_v),
        .data_o   (fifo_data),
        .yumi_i   (fifo_yumi)
    );

    // Head-of-queue decode
    logic [dest_w_lp-1:0]          head_dest;
    logic [addr_width_p-1:0]       head_ptr;
    logic [wb_stride_width_lp-1:0] head_stride;
    logic                          active, head_drop, fire, outst_ok;
    logic                          ack_ok, ack_spurious, err_clr;

    assign head_dest   = fifo_data[data_width_p +: dest_w_lp];
    assign head_ptr    = ptr_r[head_dest];
    assign head_stride = stride_r[head_dest];
    assign active      = (state_r == e_run) || (state_r == e_drain);
    assign outst_ok    = (outst_r < outst_w_lp'(max_outstanding_p));

`ifdef BP_BE_ACCEL_WB_ALIGN_CHECK_EN
    logic head_misaligned;
    assign head_misaligned = (head_ptr & addr_width_p'(bytes_lp - 1)) != '0;
    assign head_drop = fifo_v & active & ((count_r[head_dest] == '0) | head_misaligned);
`else
    assign head_drop = fifo_v & active & (count_r[head_dest] == '0);
`endif

    assign wr_v_o    = reset_n_i & fifo_v & active & ~head_drop & outst_ok;
    assign fire      = wr_v_o & wr_ready_and_i;
    assign fifo_yumi = fire | head_drop;
    assign wr_addr_o = head_ptr;
    assign wr_data_o = fifo_data[data_width_p-1:0];

    assign ack_ok       = ack_v_i & (outst_r != '0);
    assign ack_spurious = ack_v_i & (outst_r == '0);

    // CSR decode
    logic [dest_w_lp-1:0]  csr_dest;
    bp_be_accel_wb_field_e csr_field;

    assign csr_dest  = csr_addr_i[dest_w_lp+1:2];
    assign csr_field = bp_be_accel_wb_field_e'(csr_addr_i[1:0]);
    assign err_clr   = csr_w_v_i & (csr_field == e_wb_status) & csr_data_i[num_dest_p];

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        csr_data_o = '0;
        case (csr_field)
            e_wb_ptr:    csr_data_o = wb_csr_width_lp'(ptr_r[csr_dest]);
            e_wb_stride: csr_data_o = {{(wb_csr_width_lp-wb_stride_width_lp){stride_r[csr_dest][wb_stride_width_lp-1]}},
                                       stride_r[csr_dest]};
            e_wb_count:  csr_data_o = wb_csr_width_lp'(count_r[csr_dest]);
            e_wb_status: csr_data_o = wb_csr_width_lp'({err_r, done_r});
            default:     csr_data_o = '0;
        endcase
    end

    // Per-destination state. A CSR write to a field beats a same-cycle issue
    // update of that same field; other fields of the dest still advance.
    // NOTE: state is updated with non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_dest_p; i++) begin
                ptr_r[i]    <= '0;
                stride_r[i] <= '0;
                count_r[i]  <= '0;
            end
            done_r  <= '0;
            err_r   <= 1'b0;
            outst_r <= '0;
        end else begin
            for (int i = 0; i < num_dest_p; i++) begin
                if (csr_w_v_i && csr_dest == dest_w_lp'(i) && csr_field == e_wb_ptr)
                    ptr_r[i] <= csr_data_i[addr_width_p-1:0];
                else if (fire && head_dest == dest_w_lp'(i))
                    ptr_r[i] <= ptr_r[i] + {{(addr_width_p-wb_stride_width_lp){head_stride[wb_stride_width_lp-1]}},
                                            head_stride};

                if (csr_w_v_i && csr_dest == dest_w_lp'(i) && csr_field == e_wb_stride)
                    stride_r[i] <= csr_data_i[wb_stride_width_lp-1:0];

                if (csr_w_v_i && csr_dest == dest_w_lp'(i) && csr_field == e_wb_count) begin
                    count_r[i] <= csr_data_i[wb_count_width_lp-1:0];
                    done_r[i]  <= 1'b0;
                end else if (fire && head_dest == dest_w_lp'(i)) begin
                    count_r[i] <= count_r[i] - 1'b1;
                    if (count_r[i] == wb_count_width_lp'(1)) done_r[i] <= 1'b1;
                end
            end

            // A new error event in the same cycle as a clear is kept.
            if (head_drop || ack_spurious) err_r <= 1'b1;
            else if (err_clr)              err_r <= 1'b0;

            case ({fire, ack_ok})
                2'b10:   outst_r <= outst_r + 1'b1;
                2'b01:   outst_r <= outst_r - 1'b1;
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Flush FSM. An already-idle engine skips e_drain so the done pulse comes
    // the cycle right after the request.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= e_run;
            flush_done_r <= 1'b0;
        end else begin
            flush_done_r <= 1'b0;
            case (state_r)
                e_run: begin
                    if (flush_i) begin
                        if (!fifo_v && outst_r == '0 && !fifo_push) begin
                            state_r      <= e_done;
                            flush_done_r <= 1'b1;
                        end else begin
                            state_r <= e_drain;
                        end
                    end
                end
                e_drain: begin
                    if (!fifo_v && outst_r == '0) begin
                        state_r      <= e_done;
                        flush_done_r <= 1'b1;
                    end
                end
                e_done:  state_r <= e_run;
                default: state_r <= e_run;
            endcase
        end
    end

    assign flush_done_o = flush_done_r;
    assign idle_o       = ~reset_n_i | (~fifo_v & (outst_r == '0));
    assign err_o        = err_r;

endmodule
